// File: rtl/wb_mem_responder_pkg.sv
// Shared types and bus constants for the wb_mem_responder data-store bus target.
package wb_mem_responder_pkg;
    localparam int ADDR_W     = 32;
    localparam int SEL_W      = 16;
    localparam int LINE_BYTES = 16;

    typedef logic [ADDR_W-1:0]       tAddress;
    typedef logic [8*LINE_BYTES-1:0] tData128;

    typedef enum logic [2:0] {IDLE, WAIT, ACC, ACK, ERR} state_e;
endpackage

// File: rtl/resp_ram.sv
// Single-port 128-bit line RAM with per-byte write enables and a registered read port.
module resp_ram
    import wb_mem_responder_pkg::*;
#(
    parameter int LINES_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_i,
    input  logic                  wr_i,
    input  logic [SEL_W-1:0]      be_i,
    input  logic [LINES_LOG2-1:0] addr_i,
    input  tData128               wdata_i,
    output tData128               rdata_o
);
    tData128 mem [2**LINES_LOG2];

    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read register holds its value across write beats; it drives dat_o directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_o <= '0;
        else if (rd_i) rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/wb_mem_responder.sv
// Bus target backed by on-chip RAM with wait states, window error and an optional
// LR/SC reservation (enabled by defining WB_MEM_RESP_RESV_EN).
module wb_mem_responder
    import wb_mem_responder_pkg::*;
#(
    parameter int          AMSB        = 31,
    parameter int          LINES_LOG2  = 10,
    parameter logic [31:0] BASE        = 32'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [AMSB:0]     adr_i,
    input  tData128           dat_i,
    input  logic              cr_i,
    input  logic              lr_i,
    output logic              ack_o,
    output logic              err_o,
    output tData128           dat_o,
    output logic              rb_o,
    output logic              resv_v_o
);
    localparam int LW = AMSB - 3;
    localparam logic [LW-1:0] BASE_LINE = LW'(BASE >> 4);
    localparam logic [LW:0]   NLINES    = {{LW{1'b0}}, 1'b1} << LINES_LOG2;

    state_e                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    tData128               dat_q;
    logic [LINES_LOG2-1:0] line_q;
    logic                  commit;
    logic                  unused_ok;

    logic [LW-1:0]         line_full;
    logic [LW-1:0]         line_off;
    logic                  hit;
    logic [LINES_LOG2-1:0] line_idx;

    assign line_full = adr_i[AMSB:4];
    assign line_off  = line_full - BASE_LINE;
    assign hit       = (line_full >= BASE_LINE) && ({1'b0, line_off} < NLINES);
    assign line_idx  = line_off[LINES_LOG2-1:0];

`ifdef WB_MEM_RESP_RESV_EN
    logic                  cr_q;
    logic                  lr_q;
    logic                  rb_q;
    logic                  resv_v;
    logic [LINES_LOG2-1:0] resv_line;

    // A store-conditional commits only against a live reservation on its own line.
    assign commit    = !cr_q || (resv_v && resv_line == line_q);
    assign rb_o      = rb_q;
    assign resv_v_o  = resv_v;
    assign unused_ok = ^adr_i[3:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_v    <= 1'b0;
            resv_line <= '0;
        end else if (state == ACC) begin
            if (!we_q && lr_q) begin
                resv_v    <= 1'b1;
                resv_line <= line_q;
            end else if (we_q && (cr_q || line_q == resv_line)) begin
                resv_v    <= 1'b0;
            end
        end
    end
`else
    assign commit    = 1'b1;
    assign rb_o      = 1'b1;
    assign resv_v_o  = 1'b0;
    assign unused_ok = ^{adr_i[3:0], cr_i, lr_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            dat_q  <= '0;
            line_q <= '0;
`ifdef WB_MEM_RESP_RESV_EN
            cr_q   <= 1'b0;
            lr_q   <= 1'b0;
            rb_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (cyc_i && stb_i) begin
                    we_q   <= we_i;
                    sel_q  <= sel_i;
                    dat_q  <= dat_i;
                    line_q <= line_idx;
`ifdef WB_MEM_RESP_RESV_EN
                    cr_q   <= cr_i;
                    lr_q   <= lr_i;
`endif
                    cnt    <= 4'(WAIT_STATES);
                    if (!hit) begin
                        state <= ERR;
                        err_o <= 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state <= ACC;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (!cyc_i) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ACC;
                end
                ACC: begin
                    state <= ACK;
                    ack_o <= 1'b1;
`ifdef WB_MEM_RESP_RESV_EN
                    rb_q  <= commit;
`endif
                end
                ACK: if (!stb_i || !cyc_i) begin
                    state <= IDLE;
                    ack_o <= 1'b0;
                end
                ERR: if (!stb_i || !cyc_i) begin
                    state <= IDLE;
                    err_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_ram #(.LINES_LOG2(LINES_LOG2)) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rd_i    (state == ACC && !we_q),
        .wr_i    (state == ACC && we_q && commit),
        .be_i    (sel_q),
        .addr_i  (line_q),
        .wdata_i (dat_q),
        .rdata_o (dat_o)
    );
endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed table-driven bench for wb_mem_responder, with hand sequences for abort and reset.
module tb_wb_mem_responder;
`ifdef WB_MEM_RESP_RESV_EN
    localparam bit RESV = 1'b1;
`else
    localparam bit RESV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, cyc3 = 1'b0, stb = 1'b0, we = 1'b0, cr = 1'b0, lr = 1'b0;
    logic [15:0]  sel = '0;
    logic [31:0]  adr = '0;
    logic [127:0] wdat = '0;
    logic         ack, err, rb, resv;
    logic [127:0] rdat;
    logic         ack3, err3, rb3, resv3;
    logic [127:0] rdat3;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    wb_mem_responder #(.AMSB(31), .LINES_LOG2(10), .BASE(32'h0), .WAIT_STATES(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(wdat), .cr_i(cr), .lr_i(lr), .ack_o(ack), .err_o(err),
        .dat_o(rdat), .rb_o(rb), .resv_v_o(resv));

    wb_mem_responder #(.AMSB(31), .LINES_LOG2(10), .BASE(32'h0), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb), .we_i(we), .sel_i(sel),
        .adr_i(adr), .dat_i(wdat), .cr_i(cr), .lr_i(lr), .ack_o(ack3), .err_o(err3),
        .dat_o(rdat3), .rb_o(rb3), .resv_v_o(resv3));

    typedef struct {
        bit w; logic [31:0] a; logic [15:0] s; logic [127:0] d; bit c; bit l;
        int hold; bit keep; bit xerr; bit xrb; bit cd; logic [127:0] xd; bit xresv;
    } vec_t;

    function automatic vec_t mk(bit w, logic [31:0] a, logic [15:0] s, logic [127:0] d, bit c, bit l,
                                int hold, bit keep, bit xerr, bit xrb, bit cd, logic [127:0] xd, bit xresv);
        vec_t r;
        r.w = w; r.a = a; r.s = s; r.d = d; r.c = c; r.l = l; r.hold = hold; r.keep = keep;
        r.xerr = xerr; r.xrb = xrb; r.cd = cd; r.xd = xd; r.xresv = xresv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic beat(input bit d3, input bit w, input logic [31:0] a, input logic [15:0] s,
                        input logic [127:0] d, input bit c, input bit l, input int hold, input bit keep,
                        output bit rerr, output int lat, output logic [127:0] q, output logic rbv);
        bit got;
        @(negedge clk);
        if (d3) cyc3 = 1'b1; else cyc = 1'b1;
        stb = 1'b1; we = w; adr = a; sel = s; wdat = d; cr = c; lr = l;
        got = 0; lat = 0; rerr = 0; q = '0; rbv = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if ((d3 ? ack3 : ack) || (d3 ? err3 : err)) begin
                got = 1; lat = k; rerr = d3 ? err3 : err;
                q = d3 ? rdat3 : rdat; rbv = d3 ? rb3 : rb;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout adr %h no response", a);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold", {126'b0, d3 ? ack3 : ack, d3 ? err3 : err}, {126'b0, !rerr, rerr});
        end
        stb = 1'b0;
        if (!keep) begin
            if (d3) cyc3 = 1'b0; else cyc = 1'b0;
        end
        @(negedge clk);
        chk("release", {126'b0, d3 ? ack3 : ack, d3 ? err3 : err}, '0);
    endtask

    initial begin
        vec_t v[$];
        bit rerr, got;
        int lat;
        logic [127:0] q;
        logic rbv;
        logic [127:0] A, B, C, D, E, L1, L2;
        A  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        B  = {16{8'h5A}};
        C  = {16{8'hC3}};
        D  = {16{8'h77}};
        E  = {16{8'h1E}};
        L1 = RESV ? B : C;
        L2 = RESV ? D : E;

        // basic write / partial write / read
        v.push_back(mk(1, 32'h20, 16'hFFFF, A, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h20, 16'h00F0, 128'h0000000000000000_DEADBEEF_00000000, 0, 0, 2, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h20, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, 128'h00112233_44556677_DEADBEEF_CCDDEEFF, 0));
        // two beats inside one cyc
        v.push_back(mk(1, 32'h30, 16'hFFFF, A, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h40, 16'hFFFF, A, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h30, 16'hC000, B, 0, 0, 0, 1, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h40, 16'h003F, B, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h30, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, 128'h5A5A2233_44556677_8899AABB_CCDDEEFF, 0));
        v.push_back(mk(0, 32'h40, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, 128'h00112233_44556677_88995A5A_5A5A5A5A, 0));
        // out-of-window and sel=0
        v.push_back(mk(1, 32'h0, 16'hFFFF, A, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h4000, 16'hFFFF, B, 0, 0, 3, 0, 1, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h4000, 16'hFFFF, '0, 0, 0, 0, 0, 1, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h0, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, A, 0));
        v.push_back(mk(1, 32'h0, 16'h0000, B, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h0, 16'h0000, '0, 0, 0, 0, 0, 0, 1, 1, A, 0));
        // LR / SC
        v.push_back(mk(1, 32'h100, 16'hFFFF, A, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 1, 0, 0, 0, 1, 1, A, RESV));
        v.push_back(mk(1, 32'h100, 16'hFFFF, B, 1, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, B, 0));
        v.push_back(mk(1, 32'h100, 16'hFFFF, C, 1, 0, 0, 0, 0, !RESV, 0, '0, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, L1, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 1, 0, 0, 0, 1, 1, L1, RESV));
        v.push_back(mk(1, 32'h108, 16'hFFFF, D, 0, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(1, 32'h100, 16'hFFFF, E, 1, 0, 0, 0, 0, !RESV, 0, '0, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, L2, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 1, 0, 0, 0, 1, 1, L2, RESV));
        v.push_back(mk(1, 32'h200, 16'hFFFF, D, 0, 0, 0, 0, 0, 1, 0, '0, RESV));
        v.push_back(mk(1, 32'h100, 16'hFFFF, E, 1, 0, 0, 0, 0, 1, 0, '0, 0));
        v.push_back(mk(0, 32'h100, 16'hFFFF, '0, 0, 0, 0, 0, 0, 1, 1, E, 0));

        // reset state
        repeat (3) @(negedge clk);
        chk("reset ack/err", {126'b0, ack, err}, '0);
        chk("reset dat_o", rdat, '0);
        chk("reset rb_o", {127'b0, rb}, {127'b0, !RESV});
        chk("reset resv_v", {127'b0, resv}, '0);
        rst = 1'b0;

        for (int i = 0; i < v.size(); i++) begin
            beat(0, v[i].w, v[i].a, v[i].s, v[i].d, v[i].c, v[i].l, v[i].hold, v[i].keep, rerr, lat, q, rbv);
            chk($sformatf("v%0d err", i), {127'b0, rerr}, {127'b0, v[i].xerr});
            chk($sformatf("v%0d latency", i), 128'(lat), v[i].xerr ? 128'd1 : 128'd3);
            if (v[i].cd) chk($sformatf("v%0d rdata", i), q, v[i].xd);
            if (v[i].w && v[i].c) chk($sformatf("v%0d rb", i), {127'b0, rbv}, {127'b0, v[i].xrb});
            chk($sformatf("v%0d resv", i), {127'b0, resv}, {127'b0, v[i].xresv});
        end

        // WAIT_STATES=3: full write, then a write aborted in WAIT
        beat(1, 1, 32'h50, 16'hFFFF, A, 0, 0, 0, 0, rerr, lat, q, rbv);
        chk("ws3 write latency", 128'(lat), 128'd5);
        @(negedge clk);
        cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h50; sel = 16'hFFFF; wdat = B; cr = 0; lr = 0;
        @(negedge clk);
        cyc3 = 1'b0; stb = 1'b0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = got | ack3 | err3;
        end
        chk("abort no ack", {127'b0, got}, '0);
        beat(1, 0, 32'h50, 16'hFFFF, '0, 0, 0, 0, 0, rerr, lat, q, rbv);
        chk("abort line5 data", q, A);
        chk("ws3 read latency", 128'(lat), 128'd5);

        // reset asserted while ack is high
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 16'hFFFF; cr = 0; lr = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = ack;
        end
        chk("ack before reset", {127'b0, got}, 128'd1);
        rst = 1'b1;
        #1;
        chk("ack cleared by reset", {126'b0, ack, err}, '0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("idle after reset", {126'b0, ack, err}, '0);
        beat(0, 0, 32'h20, 16'hFFFF, '0, 0, 0, 0, 0, rerr, lat, q, rbv);
        chk("post-reset read", q, 128'h00112233_44556677_DEADBEEF_CCDDEEFF);
        chk("post-reset latency", 128'(lat), 128'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
